cardinal_nic_fifo: RTL and testbench
====================================

Name: cardinal_nic_fifo

Overview:
Parametrised successor to the single-entry cardinal NIC. It keeps the same 2-bit processor register map and the same router handshake (si/ri/di in, so/ro/do out). Each direction is a DEPTH-entry FIFO instead of a single buffer. Injection is gated per flit by a virtual-channel bit matched against net_polarity, and sticky overflow/underflow error flags are exposed in the status words. The block sits between a processor core and its cardinal ring router port.

Parameters:
DATA_W  64  flit and processor data width
IN_DEPTH  4  router-to-processor FIFO entries; power of 2, 2..128
OUT_DEPTH  4  processor-to-router FIFO entries; power of 2, 2..128
VC_BIT  63  bit of the head flit compared with net_polarity; must be < DATA_W

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
addr  in  2  00 IN data, 01 IN status, 10 OUT data, 11 OUT status
d_in  in  DATA_W  processor store data
d_out  out  DATA_W  processor load data, combinational
nicEn  in  1  processor access enable
nicEnWr  in  1  1 = store, 0 = load; qualified by nicEn
net_si  in  1  router presents a flit on net_di
net_ri  out  1  NIC can accept a flit; equals IN not full
net_di  in  DATA_W  flit from router
net_so  out  1  NIC presents head OUT flit, combinational
net_ro  in  1  router can accept a flit
net_do  out  DATA_W  OUT FIFO head flit
net_polarity  in  1  ring even(0)/odd(1) phase; toggles every cycle

Behaviour:
- Reset, synchronous: both FIFOs empty, pointers and counts 0, err_in = err_out = 0. After reset: net_ri=1, net_so=0, net_do=0, d_out=0.
- Status word layout, zero-extended to DATA_W:
  - IN status (addr 01): bit0 = IN nonempty; bit1 = err_in; bits[15:8] = IN count.
  - OUT status (addr 11): bit0 = OUT full; bit1 = err_out; bits[15:8] = OUT count.
- d_out:
  - nicEn=1, nicEnWr=0: addr 00 gives the IN head (0 if empty); addr 01 or 11 gives the status word; addr 10 gives 0.
  - Otherwise d_out = 0.
- Processor load, addr 00, at posedge: pops the IN head if nonempty. If IN is empty, no pop and err_in is set.
- Processor status read, addr 01 or 11, at posedge: clears the matching err flag. A set of the same flag in the same cycle wins.
- Processor store, addr 10, at posedge: pushes d_in if OUT is not full. If OUT is full, d_in is dropped, err_out is set, and the FIFO is unchanged. Stores to addr 00, 01 or 11 are ignored.
- Router ingress: at posedge, if net_si=1 and net_ri=1, push net_di. If net_si=1 and net_ri=0, the flit is not accepted; the router must hold it.
- Router egress:
  - net_so = OUT nonempty AND net_ro AND (net_polarity == head[VC_BIT]).
  - net_do = OUT head when nonempty, else 0.
  - When net_so=1 at posedge, the head is popped.
  - A head whose VC bit does not match waits for the opposite phase. With net_ro held high, that wait is at most 1 cycle. No bypass of a blocked head (strict FIFO order).
- Simultaneous events:
  - IN push and pop in the same cycle: both occur, count unchanged. Full blocks the push via net_ri=0.
  - OUT store and send in the same cycle: both occur. Fullness is judged before the pop, so a store to a full FIFO is dropped even if a send occurs that cycle.
  - Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.
- Reset mid-operation: any pending flits are discarded. net_so falls to 0 in the same cycle reset is sampled, because the FIFO empties at that edge.

Test Plan:
- Reset, then idle -> net_ri=1, net_so=0, IN status=0x0, OUT status=0x0.
- net_ro=1; store 0x...EE00 (bit63=1) and 0x...DD01 (bit63=0) back to back -> net_so=1 only in cycles with net_polarity=1 then 0 respectively, net_do matches, order preserved, OUT count returns to 0.
- net_ro=0; store 5 words to OUT_DEPTH=4 -> OUT status=0x0403 (count 4, full, err). Read it again -> 0x0401. net_ro=1 -> exactly words 1-4 drain; 5th absent.
- Router sends 0x1111, 0x2222, 0x3333, 0x4444 with net_si held -> net_ri drops after the 4th. A 5th flit 0x5555 is held until one load; loads return 1111, 2222, 3333, 4444, 5555.
- Load from empty IN -> d_out=0, then IN status reads 0x2 once, then 0x0.
- Simultaneous push and pop on both FIFOs for 10 cycles -> counts constant; data integrity across pointer wrap; reset asserted mid-stream -> both counts 0 and net_so=0 next cycle.

Source files
------------

// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo: processor/ring NIC with IN and OUT FIFOs, VC-phase gated injection and sticky error flags
module cardinal_nic_fifo #(
  parameter int DATA_W = 64,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4,
  parameter int VC_BIT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [IAW-1:0] in_rd, in_wr;
  logic [OAW-1:0] out_rd, out_wr;
  logic [IAW:0] in_cnt;
  logic [OAW:0] out_cnt;
  logic err_in, err_out, ld, st, in_empty, out_empty, out_full;
  logic in_push, in_pop, out_push;
  logic [DATA_W-1:0] in_head, out_head, in_stat, out_stat;
  always_comb begin
    ld = nicEn && !nicEnWr;
    st = nicEn && nicEnWr;
    in_empty = in_cnt == '0;
    out_empty = out_cnt == '0;
    out_full = out_cnt == (OAW+1)'(OUT_DEPTH);
    net_ri = in_cnt != (IAW+1)'(IN_DEPTH);
    in_head = in_empty ? '0 : in_mem[in_rd];
    out_head = out_empty ? '0 : out_mem[out_rd];
    in_push = net_si && net_ri;
    in_pop = ld && addr == 2'b00 && !in_empty;
    // fullness is judged before any same-cycle send
    out_push = st && addr == 2'b10 && !out_full;
    net_so = !out_empty && net_ro && net_polarity == out_head[VC_BIT];
    net_do = out_head;
    in_stat = DATA_W'({8'(in_cnt), 6'b0, err_in, !in_empty});
    out_stat = DATA_W'({8'(out_cnt), 6'b0, err_out, out_full});
    d_out = !ld ? '0 : addr == 2'b00 ? in_head : addr == 2'b01 ? in_stat : addr == 2'b11 ? out_stat : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rd <= '0;
      in_wr <= '0;
      in_cnt <= '0;
      out_rd <= '0;
      out_wr <= '0;
      out_cnt <= '0;
      err_in <= 1'b0;
      err_out <= 1'b0;
    end else begin
      in_rd <= in_rd + IAW'(in_pop);
      in_wr <= in_wr + IAW'(in_push);
      in_cnt <= in_cnt + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
      out_rd <= out_rd + OAW'(net_so);
      out_wr <= out_wr + OAW'(out_push);
      out_cnt <= out_cnt + (OAW+1)'(out_push) - (OAW+1)'(net_so);
      // a set in the same cycle as a status-read clear wins
      err_in <= (ld && addr == 2'b00 && in_empty) || (err_in && !(ld && addr == 2'b01));
      err_out <= (st && addr == 2'b10 && out_full) || (err_out && !(ld && addr == 2'b11));
    end
  end
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= net_di;
    if (out_push) out_mem[out_wr] <= d_in;
  end
endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// tb_cardinal_nic_fifo: directed test-plan sequences plus random traffic against a queue-based model
module tb_cardinal_nic_fifo;
  localparam int DW = 64, ID = 4, OD = 4, VC = 63;
  logic clk = 0, reset = 1;
  logic [1:0] addr = 0;
  logic [DW-1:0] d_in = 0, d_out, net_di = 0, net_do;
  logic nicEn = 0, nicEnWr = 0, net_si = 0, net_ri, net_so, net_ro = 0, net_polarity = 0;
  int checks = 0, failures = 0;
  bit live = 0;
  logic [DW-1:0] in_q[$], out_q[$], sent_do[$];
  logic sent_pol[$];
  bit ei, eo, m_ld, m_st, m_ipush, m_ipop, m_osend, m_ostore;

  always #5 clk = ~clk;

  cardinal_nic_fifo #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD), .VC_BIT(VC)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity));

  task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] stat(int cnt, bit e, bit b0);
    return (64'(cnt) << 8) | (64'(e) << 1) | 64'(b0);
  endfunction

  function automatic logic [DW-1:0] m_dout();
    if (!(nicEn && !nicEnWr)) return '0;
    case (addr)
      2'd0: return in_q.size() != 0 ? in_q[0] : '0;
      2'd1: return stat(in_q.size(), ei, in_q.size() != 0);
      2'd3: return stat(out_q.size(), eo, out_q.size() == OD);
      default: return '0;
    endcase
  endfunction

  function automatic bit m_so();
    return out_q.size() != 0 && net_ro && net_polarity == out_q[0][VC];
  endfunction

  always @(negedge clk) if (live) begin
    chk("net_ri", 64'(net_ri), 64'(in_q.size() < ID));
    chk("net_so", 64'(net_so), 64'(m_so()));
    chk("net_do", net_do, out_q.size() != 0 ? out_q[0] : '0);
    chk("d_out", d_out, m_dout());
  end

  always @(posedge clk) begin
    if (reset) begin
      in_q.delete();
      out_q.delete();
      ei = 0;
      eo = 0;
    end else begin
      m_ld = nicEn && !nicEnWr;
      m_st = nicEn && nicEnWr;
      m_ipush = net_si && in_q.size() < ID;
      m_ipop = m_ld && addr == 0 && in_q.size() != 0;
      m_osend = m_so();
      m_ostore = m_st && addr == 2 && out_q.size() < OD;
      if (m_ld && addr == 1) ei = 0;
      if (m_ld && addr == 0 && in_q.size() == 0) ei = 1;
      if (m_ld && addr == 3) eo = 0;
      if (m_st && addr == 2 && out_q.size() == OD) eo = 1;
      if (m_ipop) void'(in_q.pop_front());
      if (m_ipush) in_q.push_back(net_di);
      if (m_osend) void'(out_q.pop_front());
      if (m_ostore) out_q.push_back(d_in);
    end
  end

  task automatic step();
    #2;
    if (net_so) begin
      sent_do.push_back(net_do);
      sent_pol.push_back(net_polarity);
    end
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic io(input bit en, input bit wr, input logic [1:0] a, input logic [DW-1:0] d);
    nicEn = en;
    nicEnWr = wr;
    addr = a;
    d_in = d;
  endtask

  function automatic logic [DW-1:0] word(int i);
    return {i[0], 63'(i * 32'h1111)};
  endfunction

  initial begin
    logic [DW-1:0] rvals[5];
    rvals[0] = 64'h1111; rvals[1] = 64'h2222; rvals[2] = 64'h3333;
    rvals[3] = 64'h4444; rvals[4] = 64'h5555;
    step();
    step();
    reset = 0;
    live = 1;
    #1;
    chk("rst_ri", 64'(net_ri), 64'd1);
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_do", net_do, 64'd0);
    io(1, 0, 1, 0); #1 chk("rst_in_stat", d_out, 64'h0); step();
    io(1, 0, 3, 0); #1 chk("rst_out_stat", d_out, 64'h0); step();
    // VC-gated egress, strict order
    io(0, 0, 0, 0);
    net_ro = 1;
    sent_do.delete(); sent_pol.delete();
    io(1, 1, 2, 64'h8000_0000_0000_EE00); step();
    io(1, 1, 2, 64'h0000_0000_0000_DD01); step();
    io(0, 0, 0, 0);
    repeat (6) step();
    chk("vc_count", 64'(sent_do.size()), 64'd2);
    if (sent_do.size() == 2) begin
      chk("vc_first", sent_do[0], 64'h8000_0000_0000_EE00);
      chk("vc_first_pol", 64'(sent_pol[0]), 64'd1);
      chk("vc_second", sent_do[1], 64'h0000_0000_0000_DD01);
      chk("vc_second_pol", 64'(sent_pol[1]), 64'd0);
    end
    io(1, 0, 3, 0); #1 chk("vc_out_empty", d_out, 64'h0); step();
    // OUT overflow
    net_ro = 0;
    for (int i = 1; i <= 5; i++) begin
      io(1, 1, 2, word(i));
      step();
    end
    io(1, 0, 3, 0); #1 chk("ovf_stat", d_out, 64'h0403); step();
    #1 chk("ovf_stat_clr", d_out, 64'h0401); step();
    io(0, 0, 0, 0);
    net_ro = 1;
    sent_do.delete(); sent_pol.delete();
    repeat (12) step();
    chk("ovf_drain_cnt", 64'(sent_do.size()), 64'd4);
    if (sent_do.size() == 4)
      for (int i = 0; i < 4; i++) chk("ovf_drain_word", sent_do[i], word(i + 1));
    // IN fill and backpressure
    net_si = 1;
    for (int i = 0; i < 4; i++) begin
      net_di = rvals[i];
      step();
    end
    #1 chk("in_full_ri", 64'(net_ri), 64'd0);
    net_di = 64'h5555;
    step();
    #1 chk("in_hold_ri", 64'(net_ri), 64'd0);
    for (int i = 0; i < 5; i++) begin
      net_si = i <= 1;
      io(1, 0, 0, 0);
      #1 chk("in_load", d_out, rvals[i]);
      step();
    end
    net_si = 0;
    // IN underflow
    io(1, 0, 0, 0); #1 chk("uf_dout", d_out, 64'h0); step();
    io(1, 0, 1, 0); #1 chk("uf_stat", d_out, 64'h2); step();
    #1 chk("uf_stat_clr", d_out, 64'h0); step();
    io(0, 0, 0, 0);
    // simultaneous push/pop with wrap
    net_si = 1;
    repeat (2) begin net_di = {$urandom, $urandom}; step(); end
    repeat (10) begin
      net_di = {$urandom, $urandom};
      io(1, 0, 0, 0);
      step();
    end
    net_si = 0;
    io(1, 0, 1, 0); #1 chk("pp_in_stat", d_out, 64'h0201); step();
    net_ro = 0;
    repeat (2) begin io(1, 1, 2, {net_polarity, 63'($urandom)}); step(); end
    net_ro = 1;
    repeat (10) begin io(1, 1, 2, {net_polarity, 63'($urandom)}); step(); end
    net_ro = 0;
    io(1, 0, 3, 0); #1 chk("pp_out_stat", d_out, 64'h0200); step();
    // reset mid-stream
    net_ro = 1;
    net_si = 1;
    net_di = 64'hABCD;
    io(1, 1, 2, {net_polarity, 63'h77});
    reset = 1;
    step();
    reset = 0;
    net_si = 0;
    io(0, 0, 0, 0);
    #1;
    chk("mid_rst_so", 64'(net_so), 64'd0);
    chk("mid_rst_ri", 64'(net_ri), 64'd1);
    io(1, 0, 3, 0); #1 chk("mid_rst_out", d_out, 64'h0); step();
    io(1, 0, 1, 0); #1 chk("mid_rst_in", d_out, 64'h0); step();
    // random traffic
    repeat (3000) begin
      reset = $urandom_range(199) == 0;
      io(1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)), {$urandom, $urandom});
      net_si = $urandom_range(2) != 0;
      net_di = {$urandom, $urandom};
      net_ro = $urandom_range(3) != 0;
      step();
    end
    reset = 0;
    io(0, 0, 0, 0);
    net_si = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
